// File: rtl/cmos_dvp_gen.sv
// cmos_dvp_gen: DVP camera-output pattern generator.
// Emits a raster of RGB565 test patterns as a byte stream
// (high byte first) with frame sync (cam_vsync) and line valid (cam_href),
// all registered one clock after the raster position that produced them.
//
// Ports:
//   clk        byte clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   en         generation enable; a running frame always completes
//   mode       pattern: 0 colour bars, 1 gradient, 2 checker, 3 solid
//   solid_rgb  RGB565 colour for mode 3
//   cam_vsync  frame sync, high during the first V_SYNC lines
//   cam_href   line valid, high while active bytes are on cam_data
//   cam_data   pixel byte, 0 whenever cam_href is low
//   frame_done one-cycle pulse aligned with the outputs of the last count
//   frame_cnt  completed-frame counter (wraps)
module cmos_dvp_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_TOTAL  = 2240,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 16,
  parameter int V_ACTIVE = 768,
  parameter int V_TOTAL  = 1272
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BYTES    = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [15:0]   BAR_W      = 16'(H_ACTIVE / 8);
  localparam logic [15:0]   Y_OFS      = 16'(V_SYNC + V_BACK);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_h_cnt, w_h_nxt;
  logic [VW-1:0] r_v_cnt, w_v_nxt;
  logic [1:0]    r_mode_q;
  logic [15:0]   r_solid_q;
  logic          r_vsync, r_href, r_frame_done;
  logic [7:0]    r_data;
  logic [15:0]   r_frame_cnt;

  logic          w_run, w_h_last, w_v_last, w_last, w_frame_start;
  logic          w_vsync, w_href;
  logic [15:0]   w_x, w_y, w_pix;
  logic [7:0]    w_byte;

  function automatic logic [15:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pattern(input logic [1:0]  m,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [15:0] fc,
                                          input logic [15:0] sol);
    logic [15:0] bar;
    bar = x / BAR_W;
    case (m)
      2'd0:    pattern = bar_colour(bar[2:0]);
      2'd1:    pattern = {x[4:0], y[5:0], fc[4:0]};
      2'd2:    pattern = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      default: pattern = sol;
    endcase
  endfunction

  assign w_run         = (r_state == ST_RUN);
  assign w_h_last      = (r_h_cnt == H_LAST);
  assign w_v_last      = (r_v_cnt == V_LAST);
  assign w_last        = w_run && w_h_last && w_v_last;
  assign w_frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

  // Next-state / raster counters. The frame is only left at its last count,
  // so dropping en mid-frame never truncates it.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    case (r_state)
      ST_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_h_last) begin
          w_h_nxt = '0;
          if (w_v_last) begin
            w_v_nxt = '0;
            if (!en) w_state_nxt = ST_IDLE;
          end else begin
            w_v_nxt = r_v_cnt + 1'b1;
          end
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_vsync = w_run && (r_v_cnt < V_SYNC_END);
  assign w_href  = w_run && (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END) &&
                   (r_h_cnt < H_BYTES);

  // Two bytes per pixel: x drops the byte-select bit of h_cnt.
  assign w_x    = 16'(r_h_cnt[HW-1:1]);
  assign w_y    = 16'(r_v_cnt) - Y_OFS;
  assign w_pix  = pattern(r_mode_q, w_x, w_y, r_frame_cnt, r_solid_q);
  assign w_byte = !w_href ? 8'h00 : (r_h_cnt[0] ? w_pix[7:0] : w_pix[15:8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // Pattern controls are latched once per frame so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= 2'd0;
      r_solid_q <= 16'h0000;
    end else if (w_frame_start) begin
      r_mode_q  <= mode;
      r_solid_q <= solid_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'h0000;
    end else begin
      r_vsync      <= w_vsync;
      r_href       <= w_href;
      r_data       <= w_byte;
      r_frame_done <= w_last;
      r_frame_cnt  <= r_frame_cnt + {15'd0, w_last};
    end
  end

  assign cam_vsync  = r_vsync;
  assign cam_href   = r_href;
  assign cam_data   = r_data;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cmos_dvp_gen.sv
module tb_cmos_dvp_gen;

  localparam int HA = 8, HT = 20, VS = 2, VB = 2, VA = 4, VT = 10;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        cam_vsync, cam_href, frame_done;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  cmos_dvp_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model (linear frame position) ----------------
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_fcnt = 16'h0;
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_solid = 16'h0;
  logic        e_vs = 1'b0, e_href = 1'b0, e_fd = 1'b0;
  logic [7:0]  e_data = 8'h0;
  bit          preload_req = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [15:0] exp_pix(input int x, input int y, input logic [1:0] md,
                                          input logic [15:0] sol, input logic [15:0] fc);
    case (md)
      2'd0: begin
        case (x / (HA / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: return 16'(((x % 32) * 2048) + ((y % 64) * 32) + (int'(fc) % 32));
      2'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: return sol;
    endcase
  endfunction

  function automatic bit exp_href(input int pos);
    int h, v;
    h = pos % HT;
    v = pos / HT;
    return (v >= VS + VB) && (v < VS + VB + VA) && (h < 2 * HA);
  endfunction

  function automatic logic [7:0] exp_byte(input int pos, input logic [1:0] md,
                                          input logic [15:0] sol, input logic [15:0] fc);
    int h, v;
    logic [15:0] p;
    if (!exp_href(pos)) return 8'h00;
    h = pos % HT;
    v = pos / HT;
    p = exp_pix(h / 2, v - (VS + VB), md, sol, fc);
    return (h % 2 == 0) ? p[15:8] : p[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pos <= 0; m_fcnt <= 16'h0; m_mode <= 2'd0; m_solid <= 16'h0;
      e_vs <= 1'b0; e_href <= 1'b0; e_data <= 8'h0; e_fd <= 1'b0;
    end else if (!m_run) begin
      e_vs <= 1'b0; e_href <= 1'b0; e_data <= 8'h0; e_fd <= 1'b0;
      if (preload_req) m_fcnt <= 16'hFFFF;
      if (en) begin
        m_run <= 1'b1;
        m_pos <= 0;
      end
    end else begin
      if (m_pos == 0) begin
        m_mode  <= mode;
        m_solid <= solid_rgb;
      end
      e_vs   <= (m_pos / HT) < VS;
      e_href <= exp_href(m_pos);
      e_data <= exp_byte(m_pos, m_mode, m_solid, m_fcnt);
      e_fd   <= (m_pos == FRAME - 1);
      if (m_pos == FRAME - 1) begin
        m_fcnt <= m_fcnt + 16'd1;
        m_pos  <= 0;
        if (!en) m_run <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("vsync", cam_vsync, e_vs);
      check("href", cam_href, e_href);
      check("data", cam_data, e_data);
      check("frame_done", frame_done, e_fd);
      check("frame_cnt", frame_cnt, m_fcnt);
    end
  end

  // ---------------- frame capture helpers ----------------
  int         c_vs, c_href, c_fd, c_nz, c_first_href, c_first_vs, c_fc_k1;
  logic [7:0] c_line [16];
  logic       a_href [1:FRAME];
  logic [7:0] a_data [1:FRAME];
  logic [7:0] bar_line [16];

  // Starting with count 0 of a frame present, observe nc output cycles.
  // Index k holds the outputs registered from frame position k-1.
  task automatic collect(input int nc, input int hook_k, input int hook_kind,
                         input logic [1:0] hook_val);
    c_vs = 0; c_href = 0; c_fd = -1; c_nz = 0;
    c_first_href = -1; c_first_vs = -1; c_fc_k1 = -1;
    for (int k = 1; k <= nc; k++) begin
      @(posedge clk);
      #2;
      if (k == hook_k) begin
        if (hook_kind == 1) mode = hook_val;
        if (hook_kind == 2) en = 1'b0;
      end
      @(negedge clk);
      a_href[k] = cam_href;
      a_data[k] = cam_data;
      if (cam_vsync) begin
        c_vs++;
        if (c_first_vs < 0) c_first_vs = k;
      end
      if (cam_href) begin
        if (c_href < 16) c_line[c_href] = cam_data;
        if (c_first_href < 0) c_first_href = k;
        c_href++;
      end
      if (cam_data != 8'h00) c_nz++;
      if (frame_done && c_fd < 0) c_fd = k;
      if (k == 1) c_fc_k1 = int'(frame_cnt);
    end
  endtask

  task automatic wait_pos0();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk);
      #2;
      if (m_run && m_pos == 0) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL frame_start_timeout: got none want start");
    end
  endtask

  task automatic check_bar_line(input string name);
    for (int i = 0; i < 16; i++) check(name, c_line[i], bar_line[i]);
  endtask

  initial begin
    int n, hcount, rst_at;
    bit found;
    bar_line = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    #1 rst_n = 1'b0;
    #3 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vsync", cam_vsync, 0);
    check("rst_href", cam_href, 0);
    check("rst_data", cam_data, 0);
    check("rst_fd", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Colour bars, first frame after entry
    @(posedge clk); #2 mode = 2'd0; en = 1'b1;
    wait_pos0();
    collect(FRAME, 0, 0, 2'd0);
    check("f1_vsync_clks", c_vs, 40);
    check("f1_vsync_first", c_first_vs, 1);
    check("f1_href_clks", c_href, 64);
    check("f1_href_first", c_first_href, 81);
    check("f1_frame_done_clk", c_fd, 200);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    check_bar_line("f1_bar_byte");

    // Mode change mid-frame: this frame keeps bars, next is all zero
    collect(FRAME, 100, 1, 2'd2);
    check("f2_href_clks", c_href, 64);
    check_bar_line("f2_bar_byte");
    check("f2_frame_cnt", frame_cnt, 16'd2);
    collect(FRAME, 100, 2, 2'd0);
    check("f3_href_clks", c_href, 64);
    check("f3_nonzero_bytes", c_nz, 0);
    check("f3_frame_done_clk", c_fd, 200);
    check("f3_frame_cnt", frame_cnt, 16'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_vsync", cam_vsync, 0);
      check("idle_href", cam_href, 0);
      check("idle_data", cam_data, 0);
      check("idle_fcnt", frame_cnt, 16'd3);
    end

    // Solid colour
    @(posedge clk); #2 solid_rgb = 16'h1234; mode = 2'd3; en = 1'b1;
    wait_pos0();
    collect(FRAME, 0, 0, 2'd0);
    check("solid_href_clks", c_href, 64);
    n = 0; hcount = 0;
    for (int k = 1; k <= FRAME; k++) begin
      if (a_href[k]) begin
        if (a_data[k] !== ((hcount % 2 == 0) ? 8'h12 : 8'h34)) n++;
        hcount++;
      end else if (a_data[k] !== 8'h00) begin
        n++;
      end
    end
    check("solid_bytes", n, 0);

    // Asynchronous reset at h=7, v=5
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #2;
      if (m_run && m_pos == 5 * HT + 7) found = 1'b1;
    end
    check("reach_h7_v5", found, 1);
    rst_n = 1'b0;
    #1;
    check("arst_vsync", cam_vsync, 0);
    check("arst_href", cam_href, 0);
    check("arst_data", cam_data, 0);
    check("arst_fd", frame_done, 0);
    check("arst_fcnt", frame_cnt, 0);
    @(posedge clk); #2;
    @(posedge clk); #2 rst_n = 1'b1;
    wait_pos0();
    collect(FRAME, 100, 2, 2'd0);
    check("post_rst_vsync_first", c_first_vs, 1);
    check("post_rst_fcnt_k1", c_fc_k1, 0);
    check("post_rst_frame_done_clk", c_fd, 200);
    check("post_rst_fcnt", frame_cnt, 16'd1);

    // frame_cnt wrap, gradient mode blue bits follow it
    @(posedge clk); #2;
    chk_en = 1'b0;
    force dut.r_frame_cnt = 16'hFFFF;
    preload_req = 1'b1;
    @(posedge clk); #2;
    release dut.r_frame_cnt;
    preload_req = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("preload_fcnt", frame_cnt, 16'hFFFF);
    @(posedge clk); #2 mode = 2'd1; en = 1'b1;
    wait_pos0();
    collect(FRAME, 0, 0, 2'd0);
    n = 0; hcount = 0;
    for (int k = 1; k <= FRAME; k++) begin
      if (a_href[k]) begin
        if (hcount % 2 == 1 && a_data[k][4:0] !== 5'h1F) n++;
        hcount++;
      end
    end
    check("grad_blue_ffff", n, 0);
    check("wrap_fcnt", frame_cnt, 16'h0000);
    collect(FRAME, 100, 2, 2'd0);
    n = 0; hcount = 0;
    for (int k = 1; k <= FRAME; k++) begin
      if (a_href[k]) begin
        if (hcount % 2 == 1 && a_data[k][4:0] !== 5'h00) n++;
        hcount++;
      end
    end
    check("grad_blue_zero", n, 0);
    check("grad_href_clks", hcount, 64);

    // Randomized enable / mode / colour / reset
    rst_at = $urandom_range(500, 2500);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (i == rst_at) rst_n = 1'b0;
      if (i == rst_at + 2) rst_n = 1'b1;
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 63) == 0) solid_rgb = 16'($urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
